// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: command, HI/LO access and multiply/divide unit handshake
// signals between the control unit side (master) and muldiv_ctrl (slave).
interface muldiv_ctrl_if;
    // command and HI/LO access from the control unit
    logic        Start;
    logic        OpSel;
    logic [31:0] FromA;
    logic [31:0] FromB;
    logic        WriteHI;
    logic        WriteLO;
    logic [31:0] WriteData;
    logic        ReadHI;
    logic        ReadLO;

    // status and HI/LO back to the control unit
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        Div0;
    logic        Timeout;
    logic [31:0] HIOut;
    logic [31:0] LOOut;

    // operands and launch strobes to the units
    logic [31:0] UnitA;
    logic [31:0] UnitB;
    logic        MultCtrl;
    logic        DivCtrl;

    // completion and results from the units
    logic        MultDone;
    logic        DivDone;
    logic [31:0] MultHI;
    logic [31:0] MultLO;
    logic [31:0] DivHI;
    logic [31:0] DivLO;

    modport master (
        output Start, OpSel, FromA, FromB,
        output WriteHI, WriteLO, WriteData, ReadHI, ReadLO,
        output MultDone, DivDone, MultHI, MultLO, DivHI, DivLO,
        input  Busy, Stall, Done, Div0, Timeout, HIOut, LOOut,
        input  UnitA, UnitB, MultCtrl, DivCtrl
    );

    modport slave (
        input  Start, OpSel, FromA, FromB,
        input  WriteHI, WriteLO, WriteData, ReadHI, ReadLO,
        input  MultDone, DivDone, MultHI, MultLO, DivHI, DivLO,
        output Busy, Stall, Done, Div0, Timeout, HIOut, LOOut,
        output UnitA, UnitB, MultCtrl, DivCtrl
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multiply/divide units and owner of HI/LO.
// Optional build macro MULDIV_TIMEOUT_EN adds a WAIT-state watchdog that
// ends a hung operation after TIMEOUT cycles with a Timeout pulse.
//
// state  | meaning
// IDLE   | accepts Start and MTHI/MTLO writes
// LAUNCH | one-cycle launch strobe to the selected unit
// WAIT   | operands held, waiting for the selected unit's completion
// DONE   | one-cycle Done pulse (with Div0/Timeout if flagged)
module muldiv_ctrl #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input logic          Clock,
    input logic          Reset,
    muldiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic        op;
    logic        busy;
    logic        done;
    logic        div0;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        sel_done;

`ifdef MULDIV_TIMEOUT_EN
    logic [CNT_W-1:0] wdog;
    logic             timeout;
`endif

    // the watchdog must be able to hold TIMEOUT
    a_cnt_w_fits: assert property (@(posedge Clock) (2 ** CNT_W) > TIMEOUT);

    // completion of the unit that was actually launched; the other is ignored
    assign sel_done = op ? bus.DivDone : bus.MultDone;

    assign bus.Busy     = busy;
    assign bus.Stall    = busy & (bus.ReadHI | bus.ReadLO | bus.WriteHI | bus.WriteLO);
    assign bus.Done     = done;
    assign bus.Div0     = div0;
    assign bus.HIOut    = hi;
    assign bus.LOOut    = lo;
    assign bus.UnitA    = unit_a;
    assign bus.UnitB    = unit_b;
    assign bus.MultCtrl = mult_ctrl;
    assign bus.DivCtrl  = div_ctrl;

`ifdef MULDIV_TIMEOUT_EN
    assign bus.Timeout = timeout;
`else
    assign bus.Timeout = 1'b0;
`endif

    // sequencer FSM with registered strobes and the HI/LO register pair
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            op        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0      <= 1'b0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
`ifdef MULDIV_TIMEOUT_EN
            wdog      <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            // strobes default low so each lasts exactly one cycle
            done      <= 1'b0;
            div0      <= 1'b0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // MTHI/MTLO land here; a same-cycle op result overwrites later
                    if (bus.WriteHI) hi <= bus.WriteData;
                    if (bus.WriteLO) lo <= bus.WriteData;
                    if (bus.Start) begin
                        unit_a <= bus.FromA;
                        unit_b <= bus.FromB;
                        op     <= bus.OpSel;
                        busy   <= 1'b1;
                        if (bus.OpSel && (bus.FromB == 32'd0)) begin
                            // divide by zero: never launch the divider
                            state <= DONE;
                            done  <= 1'b1;
                            div0  <= 1'b1;
                        end else begin
                            state     <= LAUNCH;
                            mult_ctrl <= ~bus.OpSel;
                            div_ctrl  <= bus.OpSel;
                        end
                    end
                end
                LAUNCH: begin
`ifdef MULDIV_TIMEOUT_EN
                    wdog  <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (sel_done) begin
                        hi    <= op ? bus.DivHI : bus.MultHI;
                        lo    <= op ? bus.DivLO : bus.MultLO;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef MULDIV_TIMEOUT_EN
                    end else if (wdog == CNT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT-th WAIT cycle without completion
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized scoreboard bench for muldiv_ctrl; the bench
// plays the control unit and both arithmetic units.
module tb_muldiv_ctrl;

    localparam int TO = 10;

    logic Clock;
    logic Reset;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // MULT gives the signed 64-bit product {HI,LO}; DIV gives {quotient, remainder}
    function automatic logic [63:0] ref_result(input bit opsel, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (!opsel) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {q, r};
    endfunction

    // scoreboard monitor: every Done pulse is matched against the oldest expectation
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            chk("flag_needs_done", {31'd0, (bus.Div0 | bus.Timeout) & ~bus.Done}, 32'd0);
            if (bus.Done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", {31'd0, bus.Done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hi", bus.HIOut, e.hi);
                    chk("sb_lo", bus.LOOut, e.lo);
                    chk("sb_div0", {31'd0, bus.Div0}, {31'd0, e.div0});
                    chk("sb_timeout", {31'd0, bus.Timeout}, {31'd0, e.to});
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.Start = 0; bus.OpSel = 0; bus.FromA = 0; bus.FromB = 0;
        bus.WriteHI = 0; bus.WriteLO = 0; bus.WriteData = 0;
        bus.ReadHI = 0; bus.ReadLO = 0;
        bus.MultDone = 0; bus.DivDone = 0;
        bus.MultHI = 0; bus.MultLO = 0; bus.DivHI = 0; bus.DivLO = 0;
    endtask

    task automatic do_write(input bit h, input bit l, input logic [31:0] d);
        bus.WriteHI = h; bus.WriteLO = l; bus.WriteData = d; bus.ReadLO = 1;
        #1;
        chk("stall_idle", {31'd0, bus.Stall}, 32'd0);
        step();
        bus.WriteHI = 0; bus.WriteLO = 0; bus.ReadLO = 0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        chk("idle_write_hi", bus.HIOut, m_hi);
        chk("idle_write_lo", bus.LOOut, m_lo);
    endtask

    task automatic drive_unit(input bit opsel, input bit en, input logic [63:0] res);
        if (opsel) begin bus.DivDone = en; bus.DivHI = res[63:32]; bus.DivLO = res[31:0]; end
        else begin bus.MultDone = en; bus.MultHI = res[63:32]; bus.MultLO = res[31:0]; end
    endtask

    task automatic run_op(input bit opsel, input logic [31:0] a, input logic [31:0] b, input int d,
                          input bit level, input bit noise, input bit wr_start);
        exp_t        e;
        logic [63:0] r;
        logic [31:0] ua, ub, old_hi, old_lo, wd;
        logic        exp_stall;
        bit          z;
        z = opsel && (b == 32'd0);
        bus.Start = 1; bus.OpSel = opsel; bus.FromA = a; bus.FromB = b;
        if (wr_start) begin
            wd = $urandom;
            bus.WriteHI = 1; bus.WriteLO = 1; bus.WriteData = wd;
            m_hi = wd; m_lo = wd;
        end
        r = 64'd0;
        if (z) begin
            e = '{m_hi, m_lo, 1'b1, 1'b0};
        end else begin
            r = ref_result(opsel, a, b);
            e = '{r[63:32], r[31:0], 1'b0, 1'b0};
        end
        exp_q.push_back(e);
        old_hi = m_hi; old_lo = m_lo;
        if (!z) begin m_hi = r[63:32]; m_lo = r[31:0]; end
        step();
        bus.Start = 0; bus.WriteHI = 0; bus.WriteLO = 0;
        bus.FromA = $urandom; bus.FromB = $urandom;
        chk("busy_after_start", {31'd0, bus.Busy}, 32'd1);
        if (z) begin
            chk("div0_no_divctrl", {31'd0, bus.DivCtrl}, 32'd0);
            chk("div0_done", {31'd0, bus.Done}, 32'd1);
            chk("div0_flag", {31'd0, bus.Div0}, 32'd1);
            chk("div0_hi_kept", bus.HIOut, old_hi);
            chk("div0_lo_kept", bus.LOOut, old_lo);
            step();
            chk("div0_busy_low", {31'd0, bus.Busy}, 32'd0);
            step();
            return;
        end
        chk("launch_mult", {31'd0, bus.MultCtrl}, {31'd0, ~opsel});
        chk("launch_div", {31'd0, bus.DivCtrl}, {31'd0, opsel});
        chk("unit_a", bus.UnitA, a);
        chk("unit_b", bus.UnitB, b);
        ua = bus.UnitA; ub = bus.UnitB;
        step();
        chk("launch_one_cycle", {31'd0, bus.MultCtrl | bus.DivCtrl}, 32'd0);
        for (int i = 0; i < d; i++) begin
            if (noise) begin
                drive_unit(~opsel, 1'b1, {$urandom, $urandom});
                bus.ReadHI = 1'($urandom_range(0, 1));
                bus.WriteLO = 1; bus.WriteData = 32'hDEAD;
                bus.Start = 1'($urandom_range(0, 1)); bus.FromA = $urandom;
            end
            exp_stall = bus.ReadHI | bus.ReadLO | bus.WriteHI | bus.WriteLO;
            #1;
            chk("stall_wait", {31'd0, bus.Stall}, {31'd0, exp_stall});
            step();
            drive_unit(~opsel, 1'b0, 64'd0);
            bus.ReadHI = 0; bus.WriteLO = 0; bus.Start = 0;
            chk("wait_hi_held", bus.HIOut, old_hi);
            chk("wait_lo_held", bus.LOOut, old_lo);
            chk("wait_unit_a", bus.UnitA, ua);
            chk("wait_busy", {31'd0, bus.Busy}, 32'd1);
            chk("wait_no_done", {31'd0, bus.Done}, 32'd0);
        end
        drive_unit(opsel, 1'b1, ref_result(opsel, ua, ub));
        step();
        if (!level) drive_unit(opsel, 1'b0, 64'd0);
        chk("done_pulse", {31'd0, bus.Done}, 32'd1);
        chk("done_hi", bus.HIOut, m_hi);
        chk("done_lo", bus.LOOut, m_lo);
        chk("done_busy", {31'd0, bus.Busy}, 32'd1);
        bus.Start = 1; bus.OpSel = 0; bus.FromA = $urandom; bus.FromB = 32'd1;
        step();
        bus.Start = 0;
        drive_unit(opsel, 1'b0, 64'd0);
        chk("end_busy_low", {31'd0, bus.Busy}, 32'd0);
        chk("end_done_low", {31'd0, bus.Done}, 32'd0);
        chk("start_in_done_ignored", bus.UnitA, ua);
    endtask

`ifdef MULDIV_TIMEOUT_EN
    task automatic timeout_op(input bit opsel, input logic [31:0] a, input logic [31:0] b, input bit late_done);
        logic [63:0] r;
        r = ref_result(opsel, a, b);
        if (late_done) begin
            exp_q.push_back('{r[63:32], r[31:0], 1'b0, 1'b0});
            m_hi = r[63:32]; m_lo = r[31:0];
        end else begin
            exp_q.push_back('{m_hi, m_lo, 1'b0, 1'b1});
        end
        bus.Start = 1; bus.OpSel = opsel; bus.FromA = a; bus.FromB = b;
        step();
        bus.Start = 0;
        step();
        for (int c = 2; c <= TO + 1; c++) begin
            chk("to_wait_no_done", {31'd0, bus.Done}, 32'd0);
            if (c == TO + 1 && late_done) drive_unit(opsel, 1'b1, r);
            step();
        end
        drive_unit(opsel, 1'b0, 64'd0);
        chk("to_done", {31'd0, bus.Done}, 32'd1);
        chk("to_flag", {31'd0, bus.Timeout}, {31'd0, ~late_done});
        chk("to_hi", bus.HIOut, m_hi);
        chk("to_lo", bus.LOOut, m_lo);
        step();
        chk("to_busy_low", {31'd0, bus.Busy}, 32'd0);
    endtask
`endif

    initial begin
        bit          opsel;
        logic [31:0] a, b;
        clear_inputs();
        Reset = 1;
        repeat (3) step();
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_hi", bus.HIOut, 32'd0);
        chk("rst_lo", bus.LOOut, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        Reset = 0;

        // unit completions while idle change nothing
        for (int i = 0; i < 4; i++) begin
            bus.MultDone = 1'($urandom_range(0, 1)); bus.DivDone = 1'($urandom_range(0, 1));
            bus.MultHI = $urandom; bus.MultLO = $urandom; bus.DivHI = $urandom; bus.DivLO = $urandom;
            step();
            chk("idle_hi", bus.HIOut, 32'd0);
            chk("idle_lo", bus.LOOut, 32'd0);
            chk("idle_busy", {31'd0, bus.Busy}, 32'd0);
            chk("idle_done", {31'd0, bus.Done}, 32'd0);
        end
        clear_inputs();
        step();

        // directed: 7*6 with completion 5 cycles after launch, 100/7, 9/0
        run_op(1'b0, 32'd7, 32'd6, 4, 1'b0, 1'b1, 1'b0);
        chk("mult_7x6_hi", bus.HIOut, 32'd0);
        chk("mult_7x6_lo", bus.LOOut, 32'd42);
        run_op(1'b1, 32'd100, 32'd7, 2, 1'b1, 1'b1, 1'b0);
        chk("div_100_7_hi", bus.HIOut, 32'd14);
        chk("div_100_7_lo", bus.LOOut, 32'd2);
        run_op(1'b1, 32'd9, 32'd0, 0, 1'b0, 1'b0, 1'b0);
        chk("div0_hi_prior", bus.HIOut, 32'd14);
        chk("div0_lo_prior", bus.LOOut, 32'd2);
        do_write(1'b0, 1'b1, 32'hDEAD);
        chk("mtlo_dead", bus.LOOut, 32'hDEAD);
        do_write(1'b1, 1'b1, 32'h1234_5678);
        step();

        for (int n = 0; n < 24; n++) begin
            opsel = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 20));
            if (opsel && $urandom_range(0, 4) == 0) b = 32'd0;
            if (opsel && b == 32'hFFFF_FFFF) b = 32'd3;
            run_op(opsel, a, b, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            else
                step();
        end

`ifdef MULDIV_TIMEOUT_EN
        timeout_op(1'b0, 32'd3, 32'd5, 1'b0);
        step();
        timeout_op(1'b1, 32'd50, 32'd7, 1'b1);
        step();
`else
        run_op(1'b0, 32'hFFFF_FFFF, 32'd3, 60, 1'b0, 1'b0, 1'b0);
        step();
`endif

        // reset during WAIT abandons the op; a late unit Done is ignored
        bus.Start = 1; bus.OpSel = 0; bus.FromA = 32'd11; bus.FromB = 32'd13;
        step();
        bus.Start = 0;
        repeat (3) step();
        Reset = 1;
        step();
        Reset = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rst_wait_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_wait_hi", bus.HIOut, 32'd0);
        chk("rst_wait_lo", bus.LOOut, 32'd0);
        drive_unit(1'b0, 1'b1, 64'h5_0000_0077);
        step();
        drive_unit(1'b0, 1'b0, 64'd0);
        step();
        chk("late_done_hi", bus.HIOut, 32'd0);
        chk("late_done_lo", bus.LOOut, 32'd0);
        chk("late_done_busy", {31'd0, bus.Busy}, 32'd0);
        step();

        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer and owner of the HI/LO register pair for the multicycle CPU's multiply and divide units. It accepts MULT/DIV commands from the control unit and latches the operands. It launches the selected unit, waits for its completion, captures the result into HI/LO and reports divide-by-zero. While an operation is in flight it stalls MFHI/MFLO and MTHI/MTLO, so the control unit never reads or overwrites a stale HI/LO.

Parameters:
TIMEOUT, 48, watchdog limit in cycles spent in WAIT (used only with MULDIV_TIMEOUT_EN)
CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  command strobe, sampled in IDLE only
OpSel  in  1  0 = MULT, 1 = DIV
FromA  in  32  operand A (multiplicand / dividend)
FromB  in  32  operand B (multiplier / divisor)
WriteHI  in  1  MTHI strobe
WriteLO  in  1  MTLO strobe
WriteData  in  32  data for MTHI/MTLO
Busy  out  1  high from the cycle after an accepted Start until return to IDLE
Stall  out  1  combinational: Busy AND (ReadHI OR ReadLO OR WriteHI OR WriteLO)
ReadHI  in  1  MFHI request
ReadLO  in  1  MFLO request
Done  out  1  one-cycle pulse in the DONE state
Div0  out  1  one-cycle pulse in DONE when the op was DIV with FromB == 0
Timeout  out  1  one-cycle pulse in DONE on watchdog expiry (MULDIV_TIMEOUT_EN only; otherwise tied 0)
HIOut  out  32  HI register
LOOut  out  32  LO register
UnitA  out  32  latched operand A to the units
UnitB  out  32  latched operand B to the units
MultCtrl  out  1  launch pulse to the multiplier
DivCtrl  out  1  launch pulse to the divider
MultDone  in  1  multiplier completion, level or pulse
DivDone  in  1  divider completion, level or pulse
MultHI  in  32  multiplier high result
MultLO  in  32  multiplier low result
DivHI  in  32  divider quotient
DivLO  in  32  divider remainder

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs in any state):
  - state becomes IDLE
  - HIOut, LOOut, UnitA, UnitB become 0
  - Busy, Done, Div0, Timeout, MultCtrl, DivCtrl become 0
  - watchdog counter becomes 0
  - an in-flight operation is abandoned and its unit's Done is ignored.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - On Start=1: latch FromA→UnitA, FromB→UnitB, OpSel→op; go to LAUNCH.
  - Exception: if OpSel=1 and FromB==0, go straight to DONE with Div0 flagged. The divider is never launched and HI/LO are unchanged.
- LAUNCH (1 cycle): assert MultCtrl (op=0) or DivCtrl (op=1) for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT:
  - Hold UnitA/UnitB stable.
  - On the selected unit's Done=1: capture at that edge, go to DONE.
    - MULT: HI←MultHI, LO←MultLO.
    - DIV: HI←DivHI, LO←DivLO.
  - The non-selected unit's Done is ignored.
- DONE (1 cycle): Done=1, plus Div0/Timeout if flagged; go to IDLE.
  - Start is not accepted in DONE.
  - Minimum Start-to-Start spacing is 4 cycles.
- Latency:
  - Start edge at cycle 0; launch pulse in cycle 1.
  - If unit Done is first seen in cycle k, HI/LO are updated at the end of cycle k, Done pulses in cycle k+1 and Busy falls in cycle k+2.
- Busy = (state != IDLE).
- MTHI/MTLO:
  - Applied only when Busy=0; WriteHI writes HI, WriteLO writes LO, and both may be asserted together.
  - While Busy, the writes are not applied and Stall is raised; the control unit holds the request.
  - If WriteHI/WriteLO and Start occur in the same IDLE cycle, the write is applied and the op is also accepted; the op result later overwrites HI/LO.
- Start while Busy: ignored with no side effects. The control unit is responsible for gating Start with Busy.
- Reads: HIOut/LOOut always show the registers; Stall tells the consumer to hold off while Busy.
- Signedness: operands are passed through unmodified; the units own signed arithmetic.

Optional Feature:
MULDIV_TIMEOUT_EN:
- Defined:
  - A CNT_W-bit watchdog increments each WAIT cycle.
  - If it reaches TIMEOUT with no selected Done, go to DONE with Timeout=1 and leave HI/LO unchanged.
  - Done arriving in the same cycle as expiry wins: the result is captured and Timeout stays 0.
- Undefined: no counter is built, Timeout is tied 0, and WAIT waits indefinitely.

Test Plan:
- Reset then idle → HIOut=LOOut=0, Busy=0, Done=0; toggling MultDone/DivDone changes nothing.
- Start, OpSel=0, A=7, B=6; model MultDone 5 cycles after MultCtrl with MultHI=0, MultLO=42 → MultCtrl in cycle 1 only, HI=0/LO=42, one Done pulse, Busy low afterwards.
- Start, OpSel=1, A=100, B=7; DivHI=14, DivLO=2 → HI=14, LO=2, Div0=0.
- DIV with B=0 → DivCtrl never asserted, Done and Div0 pulse together in cycle 1, HI/LO keep their prior values.
- During WAIT: ReadHI=1 → Stall=1; WriteLO=1 with WriteData=0xDEAD → LO not written. The same write issued in IDLE → LO=0xDEAD next cycle. Start during Busy → ignored. Reset in WAIT → IDLE, and a later unit Done does not update HI/LO.
- MULDIV_TIMEOUT_EN with TIMEOUT=10, unit never completes → Timeout and Done pulse 11 cycles after launch, HI/LO unchanged. Repeat with Done arriving in the expiry cycle → result captured, Timeout=0.
